// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, status-flag bit positions and FSM state encoding for alu_core.
// The ADJ state is only present when ALU_BCD_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_ORA = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_EOR = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDA = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_SBC = 4'h7;
  localparam logic [3:0] OP_ASL = 4'h8;
  localparam logic [3:0] OP_ROL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;
  localparam logic [3:0] OP_BIT = 4'hE;
  localparam logic [3:0] OP_RSV = 4'hF;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

`ifdef ALU_BCD_EN
  typedef enum logic [1:0] {StIdle, StExec, StAdj} state_e;
`else
  typedef enum logic {StIdle, StExec} state_e;
`endif

endpackage

// File: rtl/alu_bcd_adj.sv
// alu_bcd_adj: combinational per-nibble decimal add/subtract, built only with ALU_BCD_EN.
// For subtraction the internal chain carries a borrow; carry_in/carry_out are the
// 6502-style C flag (1 = no borrow) in both directions.
module alu_bcd_adj #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             carry_out
);

  localparam int unsigned NIBBLES = WIDTH / 4;

  // Ripple nibble by nibble from the LSB, applying +6 / -6 where a nibble overflows or borrows.
  always_comb begin
    logic       c;
    logic [4:0] t;
    res = '0;
    t   = '0;
    c   = sub ? ~carry_in : carry_in;
    for (int i = 0; i < NIBBLES; i++) begin
      if (!sub) begin
        t = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0000, c};
        if (t > 5'd9) begin
          t = t + 5'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end else begin
        t = {1'b0, a[4*i+:4]} - {1'b0, b[4*i+:4]} - {4'b0000, c};
        if (t[4]) begin
          t = t - 5'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end
      res[4*i+:4] = t[3:0];
    end
    carry_out = sub ? ~c : c;
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: multi-cycle 6502-style ALU with start/done handshake and registered outputs.
// Define ALU_BCD_EN to build decimal-mode ADC/SBC (adds the ADJ state, one extra cycle).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  input  logic [7:0]       p_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [7:0]       p_out
);

  state_e           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] dst_q;
  logic [WIDTH-1:0] src_q;
  logic [7:0]       p_q;

  logic [WIDTH-1:0] alu_res;
  logic [7:0]       alu_p;
  logic [WIDTH:0]   sum;
  logic             upd_nz;

  // Binary datapath on the latched operands; unaffected flags pass through from p_q.
  always_comb begin
    alu_res = dst_q;
    alu_p   = p_q;
    sum     = '0;
    upd_nz  = 1'b0;
    case (op_q)
      OP_ORA: begin alu_res = dst_q | src_q; upd_nz = 1'b1; end
      OP_AND: begin alu_res = dst_q & src_q; upd_nz = 1'b1; end
      OP_EOR: begin alu_res = dst_q ^ src_q; upd_nz = 1'b1; end
      OP_LDA: begin alu_res = src_q;         upd_nz = 1'b1; end
      OP_INC: begin alu_res = dst_q + WIDTH'(1); upd_nz = 1'b1; end
      OP_DEC: begin alu_res = dst_q - WIDTH'(1); upd_nz = 1'b1; end
      OP_ADC: begin
        sum = {1'b0, dst_q} + {1'b0, src_q} + (WIDTH+1)'(p_q[FLAG_C]);
        alu_res = sum[WIDTH-1:0];
        alu_p[FLAG_C] = sum[WIDTH];
        alu_p[FLAG_V] = (dst_q[WIDTH-1] == src_q[WIDTH-1]) &&
                        (alu_res[WIDTH-1] != dst_q[WIDTH-1]);
        upd_nz = 1'b1;
      end
      // Subtraction as dst + ~src + C, so the carry out is the no-borrow flag.
      OP_SBC: begin
        sum = {1'b0, dst_q} + {1'b0, ~src_q} + (WIDTH+1)'(p_q[FLAG_C]);
        alu_res = sum[WIDTH-1:0];
        alu_p[FLAG_C] = sum[WIDTH];
        alu_p[FLAG_V] = (dst_q[WIDTH-1] != src_q[WIDTH-1]) &&
                        (alu_res[WIDTH-1] != dst_q[WIDTH-1]);
        upd_nz = 1'b1;
      end
      OP_CMP: begin
        sum = {1'b0, dst_q} + {1'b0, ~src_q} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_p[FLAG_C] = sum[WIDTH];
        upd_nz = 1'b1;
      end
      OP_ASL: begin {alu_p[FLAG_C], alu_res} = {dst_q, 1'b0};          upd_nz = 1'b1; end
      OP_ROL: begin {alu_p[FLAG_C], alu_res} = {dst_q, p_q[FLAG_C]};   upd_nz = 1'b1; end
      OP_LSR: begin {alu_res, alu_p[FLAG_C]} = {1'b0, dst_q};          upd_nz = 1'b1; end
      OP_ROR: begin {alu_res, alu_p[FLAG_C]} = {p_q[FLAG_C], dst_q};   upd_nz = 1'b1; end
      OP_BIT: begin
        alu_p[FLAG_Z] = ((dst_q & src_q) == '0);
        alu_p[FLAG_N] = src_q[WIDTH-1];
        alu_p[FLAG_V] = src_q[WIDTH-2];
      end
      default: ; // STA and reserved: res = dst, flags unchanged
    endcase
    if (upd_nz) begin
      alu_p[FLAG_N] = alu_res[WIDTH-1];
      alu_p[FLAG_Z] = (alu_res == '0);
    end
  end

`ifdef ALU_BCD_EN
  logic [WIDTH-1:0] bcd_res;
  logic             bcd_c;
  logic [7:0]       bcd_p;
  logic             is_dec;

  alu_bcd_adj #(
    .WIDTH(WIDTH)
  ) u_bcd_adj (
    .a        (dst_q),
    .b        (src_q),
    .carry_in (p_q[FLAG_C]),
    .sub      (op_q == OP_SBC),
    .res      (bcd_res),
    .carry_out(bcd_c)
  );

  assign is_dec = ((op_q == OP_ADC) || (op_q == OP_SBC)) && p_q[FLAG_D];

  // Decimal flags: V stays from the binary result, N/Z/C come from the adjusted value.
  always_comb begin
    bcd_p         = alu_p;
    bcd_p[FLAG_C] = bcd_c;
    bcd_p[FLAG_N] = bcd_res[WIDTH-1];
    bcd_p[FLAG_Z] = (bcd_res == '0);
  end
`endif

  // Control FSM with operand latches and registered result/status/handshake outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      p_out <= 8'h00;
      op_q  <= 4'h0;
      dst_q <= '0;
      src_q <= '0;
      p_q   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            op_q  <= op;
            dst_q <= dst;
            src_q <= src;
            p_q   <= p_in;
            busy  <= 1'b1;
            state <= StExec;
          end
        end
        StExec: begin
`ifdef ALU_BCD_EN
          if (is_dec) begin
            state <= StAdj;
          end else
`endif
          begin
            res   <= alu_res;
            p_out <= alu_p;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
`ifdef ALU_BCD_EN
        StAdj: begin
          res   <= bcd_res;
          p_out <= bcd_p;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule
